// File: rtl/fuse_key_loader.sv
// fuse_key_loader: register-mapped fuse key fetch engine with per-word timeout and sticky lock
module fuse_key_loader #(
   parameter int NUM_KEYS      = 4,
   parameter int KEY_WORDS     = 2,
   parameter int FUSE_MEM_SIZE = 34,
   parameter int TIMEOUT       = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        reg_write_i,
   input  logic [7:0]  reg_addr_i,
   input  logic [31:0] reg_wdata_i,
   output logic [31:0] reg_rdata_o,
   output logic        reg_ready_o,
   output logic        reg_error_o,
   output logic        fuse_req_o,
   output logic [31:0] fuse_addr_o,
   input  logic [31:0] fuse_rdata_i,
   input  logic        fuse_rvalid_i
);
   localparam int IW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
   localparam int TW = $clog2(TIMEOUT);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
   state_t state, state_n;
   logic [31:0] base;
   logic [7:0] key_sel;
   logic [31:0] key [KEY_WORDS];
   logic busy, done, err, lock;
   logic [TW-1:0] tcnt;
   logic [IW-1:0] idx;
   logic [5:0] ridx;
   logic wr_ctrl, wr_base, start_ok, start_bad, last_word, tmo;
   logic [39:0] last_addr;
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^reg_addr_i[1:0];
   assign ridx = reg_addr_i[7:2];
   assign wr_ctrl = reg_write_i && ridx == 6'd0;
   assign wr_base = reg_write_i && ridx == 6'd2;
   assign start_ok = wr_ctrl && reg_wdata_i[0] && !reg_wdata_i[1] && state == S_IDLE && !lock;
   // range check is done in 40 bits so a huge BASE cannot wrap into the valid range
   assign last_addr = {8'b0, base} + 40'(reg_wdata_i[15:8]) * 40'(KEY_WORDS) + 40'(KEY_WORDS - 1);
   assign start_bad = {24'b0, reg_wdata_i[15:8]} >= 32'(NUM_KEYS) || last_addr >= 40'(FUSE_MEM_SIZE);
   assign last_word = idx == IW'(KEY_WORDS - 1);
   assign tmo = tcnt == TW'(TIMEOUT - 1);
   assign fuse_req_o = state == S_REQ;
   assign fuse_addr_o = fuse_req_o ? base + 32'(key_sel) * 32'(KEY_WORDS) + 32'(idx) : 32'd0;
   assign reg_ready_o = 1'b1;
   assign reg_error_o = ridx > 6'(2 + KEY_WORDS);
   always_comb begin
      reg_rdata_o = 32'd0;
      if (ridx == 6'd0) reg_rdata_o = {16'b0, key_sel, 8'b0};
      if (ridx == 6'd1) reg_rdata_o = {28'b0, lock, err, done, busy};
      if (ridx == 6'd2) reg_rdata_o = base;
      for (int i = 0; i < KEY_WORDS; i++)
         if (!lock && ridx == 6'(3 + i)) reg_rdata_o = key[i];
   end
   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE: state_n = (start_ok && !start_bad) ? S_REQ : S_IDLE;
         S_REQ:  state_n = S_WAIT;
         S_WAIT: state_n = fuse_rvalid_i ? (last_word ? S_DONE : S_REQ) : (tmo ? S_IDLE : S_WAIT);
         S_DONE: state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= S_IDLE;
         base <= '0;
         key_sel <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
         lock <= 1'b0;
         tcnt <= '0;
         idx <= '0;
         for (int i = 0; i < KEY_WORDS; i++) key[i] <= '0;
      end else begin
         state <= state_n;
         if (wr_ctrl && reg_wdata_i[1]) lock <= 1'b1;
         if (wr_base && !busy && !lock) base <= reg_wdata_i;
         if (start_ok) begin
            key_sel <= reg_wdata_i[15:8];
            done <= 1'b0;
            idx <= '0;
            err <= start_bad;
            busy <= !start_bad;
         end
         if (state == S_REQ) tcnt <= '0;
         if (state == S_WAIT) begin
            if (fuse_rvalid_i) begin
               key[idx] <= fuse_rdata_i;
               if (!last_word) idx <= idx + 1'b1;
            end else if (tmo) begin
               err <= 1'b1;
               busy <= 1'b0;
               for (int i = 0; i < KEY_WORDS; i++) key[i] <= '0;
            end else tcnt <= tcnt + 1'b1;
         end
         if (state == S_DONE) begin
            done <= 1'b1;
            busy <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fuse_key_loader.sv
// tb_fuse_key_loader: directed stimulus, transaction-level model checked every cycle, literal spot checks
module tb_fuse_key_loader;
   localparam int KW = 2, NK = 4, FMS = 34, TO = 16;
   logic clk = 1'b0, rst = 1'b1, reg_write = 1'b0;
   logic [7:0] reg_addr = 8'h04;
   logic [31:0] reg_wdata = '0, reg_rdata, fuse_addr, fuse_rdata;
   logic reg_ready, reg_error, fuse_req, fuse_rvalid;
   always #5 clk = ~clk;
   fuse_key_loader dut (
      .clk_i(clk), .rst_i(rst), .reg_write_i(reg_write), .reg_addr_i(reg_addr),
      .reg_wdata_i(reg_wdata), .reg_rdata_o(reg_rdata), .reg_ready_o(reg_ready),
      .reg_error_o(reg_error), .fuse_req_o(fuse_req), .fuse_addr_o(fuse_addr),
      .fuse_rdata_i(fuse_rdata), .fuse_rvalid_i(fuse_rvalid)
   );
   logic [31:0] fmem [64];
   logic resp_en = 1'b1, pend = 1'b0, man_rv = 1'b0;
   logic [31:0] pdata = '0, man_rd = '0;
   always @(posedge clk) begin
      pend <= resp_en && fuse_req;
      pdata <= fmem[fuse_addr[5:0]];
   end
   assign fuse_rvalid = pend || man_rv;
   assign fuse_rdata = pend ? pdata : man_rd;
   logic [31:0] q [$];
   always @(negedge clk) if (fuse_req) q.push_back(fuse_addr);
   int n_cmp = 0, n_bad = 0;
   bit chk_en = 1'b0;
   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   // model: a fetch is a list of words still to request; only the bus-visible effects are tracked
   logic [31:0] m_base = '0, m_key [KW];
   logic [7:0] m_ks = '0;
   bit m_busy = 0, m_done = 0, m_err = 0, m_lock = 0, m_req = 0, m_waiting = 0, m_fin = 0;
   int m_word = 0, m_waited = 0;
   initial foreach (m_key[i]) m_key[i] = '0;
   always @(posedge clk) begin
      bit idle, wr;
      logic [5:0] wi;
      if (rst) begin
         m_base = '0; m_ks = '0; m_busy = 0; m_done = 0; m_err = 0; m_lock = 0;
         m_req = 0; m_waiting = 0; m_fin = 0; m_word = 0; m_waited = 0;
         foreach (m_key[i]) m_key[i] = '0;
      end else begin
         idle = !m_busy;
         wr = reg_write;
         wi = reg_addr[7:2];
         if (m_req) begin
            m_req = 0; m_waiting = 1; m_waited = 0;
         end else if (m_waiting) begin
            if (fuse_rvalid) begin
               m_key[m_word] = fuse_rdata;
               m_waiting = 0;
               if (m_word == KW - 1) m_fin = 1;
               else begin m_word++; m_req = 1; end
            end else if (m_waited == TO - 1) begin
               m_err = 1; m_busy = 0; m_waiting = 0;
               foreach (m_key[i]) m_key[i] = '0;
            end else m_waited++;
         end else if (m_fin) begin
            m_fin = 0; m_done = 1; m_busy = 0;
         end
         if (wr && wi == 0 && reg_wdata[1:0] == 2'b01 && idle && !m_lock) begin
            m_ks = reg_wdata[15:8]; m_done = 0; m_err = 0; m_word = 0;
            if (int'(m_ks) >= NK || longint'(m_base) + longint'(m_ks) * KW + KW - 1 >= FMS) m_err = 1;
            else begin m_busy = 1; m_req = 1; end
         end
         if (wr && wi == 2 && idle && !m_lock) m_base = reg_wdata;
         if (wr && wi == 0 && reg_wdata[1]) m_lock = 1;
      end
   end
   function automatic logic [31:0] exp_rd(logic [5:0] a);
      if (a == 0) return {16'b0, m_ks, 8'b0};
      if (a == 1) return {28'b0, m_lock, m_err, m_done, m_busy};
      if (a == 2) return m_base;
      if (a >= 3 && a < 3 + KW) return m_lock ? 32'd0 : m_key[a - 3];
      return 32'd0;
   endfunction
   always @(negedge clk) if (chk_en) begin
      check("cmp_req", {31'b0, fuse_req}, {31'b0, m_req});
      check("cmp_faddr", fuse_addr, m_req ? m_base + 32'(m_ks) * KW + 32'(m_word) : 32'd0);
      check("cmp_rdata", reg_rdata, exp_rd(reg_addr[7:2]));
      check("cmp_error", {31'b0, reg_error}, {31'b0, reg_addr[7:2] > 6'(2 + KW)});
      check("cmp_ready", {31'b0, reg_ready}, 32'd1);
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wr(logic [7:0] a, logic [31:0] d);
      reg_write = 1'b1; reg_addr = a; reg_wdata = d;
      tick();
      reg_write = 1'b0; reg_addr = 8'h04;
   endtask
   task automatic lit(string nm, logic [7:0] a, logic [31:0] e);
      reg_addr = a;
      @(negedge clk);
      check(nm, reg_rdata, e);
   endtask
   task automatic wait_done(int bound);
      int i;
      reg_addr = 8'h04;
      #1;
      for (i = 0; i < bound; i++) begin
         if (!reg_rdata[0]) break;
         tick();
      end
      check("wait_done_bound", {31'b0, i < bound}, 32'd1);
   endtask
   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask
   task automatic chk_q(string nm, int n, logic [31:0] a0, logic [31:0] a1);
      check({nm, "_cnt"}, q.size(), n);
      if (n > 0) check({nm, "_a0"}, q.size() > 0 ? q[0] : 32'hx, a0);
      if (n > 1) check({nm, "_a1"}, q.size() > 1 ? q[1] : 32'hx, a1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      for (int i = 0; i < 64; i++) fmem[i] = 32'h1000_0000 + i * 32'h0101;
      fmem[6'h12] = 32'hDEADBEEF;
      fmem[6'h13] = 32'hCAFEF00D;
      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      lit("rst_status", 8'h04, 32'h0);
      lit("rst_key0", 8'h0C, 32'h0);
      lit("rst_key1", 8'h10, 32'h0);
      lit("rst_base", 8'h08, 32'h0);
      // basic fetch with latency pinning
      wr(8'h08, 32'h10);
      q.delete();
      wr(8'h00, 32'h101);
      repeat (4) tick();
      lit("busy_c4", 8'h04, 32'h1);
      tick();
      lit("done_c5", 8'h04, 32'h2);
      chk_q("fetch1", 2, 32'h12, 32'h13);
      lit("fetch1_key0", 8'h0C, 32'hDEADBEEF);
      lit("fetch1_key1", 8'h10, 32'hCAFEF00D);
      lit("fetch1_ctrl", 8'h00, 32'h100);
      // range errors and the highest legal address
      wr(8'h08, 32'h0);
      q.delete();
      wr(8'h00, 32'h501);
      tick();
      lit("ks5_status", 8'h04, 32'h4);
      lit("ks5_ctrl", 8'h00, 32'h500);
      chk_q("ks5", 0, 0, 0);
      wr(8'h08, 32'd26);
      q.delete();
      wr(8'h00, 32'h301);
      wait_done(20);
      lit("edge_ok_status", 8'h04, 32'h2);
      chk_q("edge_ok", 2, 32'd32, 32'd33);
      wr(8'h08, 32'd27);
      q.delete();
      wr(8'h00, 32'h301);
      tick();
      lit("edge_bad_status", 8'h04, 32'h4);
      chk_q("edge_bad", 0, 0, 0);
      // timeout, then recovery
      resp_en = 1'b0;
      wr(8'h08, 32'h0);
      wr(8'h00, 32'h001);
      repeat (16) tick();
      lit("tmo_c16", 8'h04, 32'h1);
      tick();
      lit("tmo_status", 8'h04, 32'h4);
      lit("tmo_key0", 8'h0C, 32'h0);
      lit("tmo_key1", 8'h10, 32'h0);
      resp_en = 1'b1;
      wr(8'h00, 32'h001);
      wait_done(20);
      lit("recover_status", 8'h04, 32'h2);
      lit("recover_key0", 8'h0C, 32'h1000_0000);
      // rvalid exactly at the terminal count is accepted
      resp_en = 1'b0;
      wr(8'h00, 32'h001);
      repeat (16) tick();
      man_rv = 1'b1;
      man_rd = 32'h1234_5678;
      tick();
      man_rv = 1'b0;
      resp_en = 1'b1;
      wait_done(20);
      lit("tc_status", 8'h04, 32'h2);
      lit("tc_key0", 8'h0C, 32'h1234_5678);
      lit("tc_key1", 8'h10, 32'h1000_0101);
      // start while busy is ignored
      wr(8'h08, 32'h10);
      q.delete();
      wr(8'h00, 32'h101);
      wr(8'h00, 32'h201);
      wait_done(20);
      lit("busy_ctrl", 8'h00, 32'h100);
      chk_q("busy", 2, 32'h12, 32'h13);
      lit("busy_key1", 8'h10, 32'hCAFEF00D);
      // lock
      wr(8'h00, 32'h002);
      lit("lock_status", 8'h04, 32'hA);
      lit("lock_key0", 8'h0C, 32'h0);
      lit("lock_key1", 8'h10, 32'h0);
      wr(8'h08, 32'h20);
      lit("lock_base", 8'h08, 32'h10);
      q.delete();
      wr(8'h00, 32'h201);
      repeat (3) tick();
      lit("lock_start_status", 8'h04, 32'hA);
      lit("lock_start_ctrl", 8'h00, 32'h100);
      chk_q("lock_start", 0, 0, 0);
      do_reset();
      lit("unlock_status", 8'h04, 32'h0);
      lit("unlock_key0", 8'h0C, 32'h0);
      lit("unlock_base", 8'h08, 32'h0);
      // start and lock in one write
      q.delete();
      wr(8'h00, 32'h103);
      repeat (3) tick();
      lit("startlock_status", 8'h04, 32'h8);
      lit("startlock_ctrl", 8'h00, 32'h0);
      chk_q("startlock", 0, 0, 0);
      do_reset();
      // reset during WAIT, late rvalid ignored
      resp_en = 1'b0;
      wr(8'h08, 32'h10);
      wr(8'h00, 32'h101);
      tick();
      tick();
      rst = 1'b1;
      tick();
      lit("rstwait_status", 8'h04, 32'h0);
      rst = 1'b0;
      man_rv = 1'b1;
      man_rd = 32'hFFFF_FFFF;
      tick();
      man_rv = 1'b0;
      resp_en = 1'b1;
      repeat (3) tick();
      lit("late_rv_status", 8'h04, 32'h0);
      lit("late_rv_key0", 8'h0C, 32'h0);
      // lock set mid-fetch: fetch finishes, key stays hidden
      wr(8'h08, 32'h10);
      wr(8'h00, 32'h101);
      wr(8'h00, 32'h002);
      wait_done(20);
      lit("midlock_status", 8'h04, 32'hA);
      lit("midlock_key0", 8'h0C, 32'h0);
      do_reset();
      // address decode errors
      reg_addr = 8'hFC;
      @(negedge clk);
      check("idx63_error", {31'b0, reg_error}, 32'd1);
      check("idx63_rdata", reg_rdata, 32'h0);
      reg_addr = 8'h14;
      @(negedge clk);
      check("idx5_error", {31'b0, reg_error}, 32'd1);
      reg_addr = 8'h10;
      @(negedge clk);
      check("idx4_error", {31'b0, reg_error}, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
